// File: rtl/dual_port_sync_ram_be_if.sv
// Bus bundle for dual_port_sync_ram_be.
//   master : producer/consumer side; drives write and read requests.
//   slave  : the RAM; returns read data, read valid and init_busy.
// Signals: wr_en, wr_addr, wr_data, wr_be, rd_en, rd_addr, rd_data, rd_valid, init_busy.
interface dual_port_sync_ram_be_if #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 4
);
   localparam int BE_WIDTH = DATA_WIDTH / 8;

   logic                  wr_en;
   logic [ADDR_WIDTH-1:0] wr_addr;
   logic [DATA_WIDTH-1:0] wr_data;
   logic [BE_WIDTH-1:0]   wr_be;
   logic                  rd_en;
   logic [ADDR_WIDTH-1:0] rd_addr;
   logic [DATA_WIDTH-1:0] rd_data;
   logic                  rd_valid;
   logic                  init_busy;

   modport master (
      output wr_en, wr_addr, wr_data, wr_be, rd_en, rd_addr,
      input  rd_data, rd_valid, init_busy
   );

   modport slave (
      input  wr_en, wr_addr, wr_data, wr_be, rd_en, rd_addr,
      output rd_data, rd_valid, init_busy
   );
endinterface

// File: rtl/dual_port_sync_ram_be.sv
// Simple dual-port synchronous RAM with per-byte write enables, selectable
// read latency (OUT_REG), read-during-write mode (RDW_MODE) and an optional
// post-reset clear sequencer (CLEAR_ON_RESET).
// Ports:
//   clk   : clock, all state updates on rising edge
//   rst_n : asynchronous active-low reset
//   bus   : dual_port_sync_ram_be_if slave modport (write port, read port,
//           rd_data/rd_valid, init_busy)
//
// state | meaning
// ------+-----------------------------------------------------------
// INIT  | clearing one word per cycle from address 0; requests ignored
// READY | normal read/write operation until the next reset
module dual_port_sync_ram_be #(
   parameter int DATA_WIDTH     = 32,
   parameter int DEPTH          = 16,
   parameter int ADDR_WIDTH     = 4,
   parameter int OUT_REG        = 0,
   parameter int RDW_MODE       = 1,
   parameter int CLEAR_ON_RESET = 1
) (
   input logic                    clk,
   input logic                    rst_n,
   dual_port_sync_ram_be_if.slave bus
);
   localparam int BE_WIDTH = DATA_WIDTH / 8;
   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
   localparam logic [ADDR_WIDTH:0]   DEPTH_L   = (ADDR_WIDTH + 1)'(DEPTH);

   typedef enum logic {ST_INIT, ST_READY} state_t;

   state_t                state_q, state_d;
   logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
   logic [DATA_WIDTH-1:0] mem_q [DEPTH];

   logic                  wr_in_range, rd_in_range, wr_ok, rd_ok;
   logic [DATA_WIDTH-1:0] rd_word;
   logic                  s1_valid_q;
   logic [DATA_WIDTH-1:0] s1_data_q;

   assign wr_in_range = ({1'b0, bus.wr_addr} < DEPTH_L);
   assign rd_in_range = ({1'b0, bus.rd_addr} < DEPTH_L);
   assign wr_ok       = (state_q == ST_READY) && bus.wr_en && wr_in_range;
   assign rd_ok       = (state_q == ST_READY) && bus.rd_en;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= (CLEAR_ON_RESET != 0) ? ST_INIT : ST_READY;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      if (state_q == ST_INIT) begin
         cnt_d = cnt_q + 1'b1;
         if (cnt_q == LAST_ADDR) begin
            state_d = ST_READY;
         end
      end
   end

   // Array has no reset; INIT clears it word by word instead.
   always_ff @(posedge clk) begin
      if (state_q == ST_INIT) begin
         mem_q[cnt_q] <= '0;
      end else if (wr_ok) begin
         for (int b = 0; b < BE_WIDTH; b++) begin
            if (bus.wr_be[b]) begin
               mem_q[bus.wr_addr][8*b +: 8] <= bus.wr_data[8*b +: 8];
            end
         end
      end
   end

   // Out-of-range reads return zero; write-first forwards enabled bytes on collision.
   always_comb begin
      rd_word = '0;
      if (rd_in_range) begin
         rd_word = mem_q[bus.rd_addr];
         if ((RDW_MODE != 0) && wr_ok && (bus.wr_addr == bus.rd_addr)) begin
            for (int b = 0; b < BE_WIDTH; b++) begin
               if (bus.wr_be[b]) begin
                  rd_word[8*b +: 8] = bus.wr_data[8*b +: 8];
               end
            end
         end
      end
   end

   // Data registers load only on a valid read so rd_data holds between pulses.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid_q <= 1'b0;
         s1_data_q  <= '0;
      end else begin
         s1_valid_q <= rd_ok;
         if (rd_ok) begin
            s1_data_q <= rd_word;
         end
      end
   end

   generate
      if (OUT_REG != 0) begin : g_out_reg
         logic                  s2_valid_q;
         logic [DATA_WIDTH-1:0] s2_data_q;

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               s2_valid_q <= 1'b0;
               s2_data_q  <= '0;
            end else begin
               s2_valid_q <= s1_valid_q;
               if (s1_valid_q) begin
                  s2_data_q <= s1_data_q;
               end
            end
         end

         assign bus.rd_valid = s2_valid_q;
         assign bus.rd_data  = s2_data_q;
      end else begin : g_no_out_reg
         assign bus.rd_valid = s1_valid_q;
         assign bus.rd_data  = s1_data_q;
      end
   endgenerate

   assign bus.init_busy = (state_q == ST_INIT);
endmodule

// File: tb/tb_dual_port_sync_ram_be.sv
// Two instances share one stimulus stream:
//   dut 0 : DEPTH 16, OUT_REG 0, RDW_MODE 1 (write-first)
//   dut 1 : DEPTH 12, OUT_REG 1, RDW_MODE 0 (read-first), addresses 12..15 out of range
// Each is checked every cycle against a word-array model with a per-cycle output schedule.
module tb_dual_port_sync_ram_be;
   localparam int DW = 32;
   localparam int AW = 4;

   logic clk = 1'b0;
   logic rst_n = 1'b1;

   logic          wr_en = 1'b0;
   logic [AW-1:0] wr_addr = '0;
   logic [DW-1:0] wr_data = '0;
   logic [3:0]    wr_be = '0;
   logic          rd_en = 1'b0;
   logic [AW-1:0] rd_addr = '0;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   int dep  [2] = '{16, 12};
   int oreg [2] = '{0, 1};
   int rdw  [2] = '{1, 0};

   logic [DW-1:0] model   [2][16];
   bit            sched_v [2][64];
   logic [DW-1:0] sched_d [2][64];
   logic [DW-1:0] last_d  [2];
   int            init_left [2];
   logic [33:0]   exp_o [2];
   logic [33:0]   obs   [2];

   dual_port_sync_ram_be_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) if_a ();
   dual_port_sync_ram_be_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) if_b ();

   assign if_a.wr_en = wr_en;   assign if_b.wr_en = wr_en;
   assign if_a.wr_addr = wr_addr; assign if_b.wr_addr = wr_addr;
   assign if_a.wr_data = wr_data; assign if_b.wr_data = wr_data;
   assign if_a.wr_be = wr_be;   assign if_b.wr_be = wr_be;
   assign if_a.rd_en = rd_en;   assign if_b.rd_en = rd_en;
   assign if_a.rd_addr = rd_addr; assign if_b.rd_addr = rd_addr;

   assign obs[0] = {if_a.init_busy, if_a.rd_valid, if_a.rd_data};
   assign obs[1] = {if_b.init_busy, if_b.rd_valid, if_b.rd_data};

   dual_port_sync_ram_be #(
      .DATA_WIDTH(DW), .DEPTH(16), .ADDR_WIDTH(AW),
      .OUT_REG(0), .RDW_MODE(1), .CLEAR_ON_RESET(1)
   ) u_dut_a (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (if_a)
   );

   dual_port_sync_ram_be #(
      .DATA_WIDTH(DW), .DEPTH(12), .ADDR_WIDTH(AW),
      .OUT_REG(1), .RDW_MODE(0), .CLEAR_ON_RESET(1)
   ) u_dut_b (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (if_b)
   );

   always #5 clk = ~clk;

   function automatic logic [DW-1:0] merge(input logic [DW-1:0] old_w,
                                           input logic [DW-1:0] new_w,
                                           input logic [3:0] be);
      logic [DW-1:0] r;
      r = old_w;
      for (int b = 0; b < 4; b++) begin
         if (be[b]) r[8*b +: 8] = new_w[8*b +: 8];
      end
      return r;
   endfunction

   // Drive one cycle, advance the model across the edge, compute expected outputs.
   task automatic step(input logic we, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                       input logic [3:0] be, input logic re, input logic [AW-1:0] ra);
      logic [DW-1:0] r;
      int slot;
      logic v;
      wr_en = we; wr_addr = wa; wr_data = wd; wr_be = be; rd_en = re; rd_addr = ra;
      @(posedge clk);
      cyc++;
      for (int k = 0; k < 2; k++) begin
         if (init_left[k] > 0) begin
            model[k][dep[k] - init_left[k]] = '0;
            init_left[k]--;
         end else begin
            if (re) begin
               r = '0;
               if (int'(ra) < dep[k]) begin
                  r = model[k][ra];
                  if (rdw[k] != 0 && we && wa == ra) r = merge(r, wd, be);
               end
               slot = (cyc + oreg[k]) % 64;
               sched_v[k][slot] = 1'b1;
               sched_d[k][slot] = r;
            end
            if (we && int'(wa) < dep[k]) model[k][wa] = merge(model[k][wa], wd, be);
         end
      end
      #1;
      for (int k = 0; k < 2; k++) begin
         slot = cyc % 64;
         v = 1'b0;
         if (sched_v[k][slot]) begin
            v = 1'b1;
            last_d[k] = sched_d[k][slot];
            sched_v[k][slot] = 1'b0;
         end
         exp_o[k] = {init_left[k] > 0, v, last_d[k]};
      end
   endtask

   task automatic idle();
      step(1'b0, '0, '0, 4'h0, 1'b0, '0);
   endtask

   // Asserts reset away from the clock edge, checks the reset outputs, releases on a negedge.
   task automatic reset_dut(input string tag);
      rst_n = 1'b0;
      for (int k = 0; k < 2; k++) begin
         for (int s = 0; s < 64; s++) sched_v[k][s] = 1'b0;
         last_d[k] = '0;
         init_left[k] = dep[k];
      end
      #1;
      for (int k = 0; k < 2; k++) begin
         checks++;
         if (obs[k] !== {1'b1, 1'b0, 32'h0}) begin
            errors++;
            $display("FAIL %s dut%0d in reset: got busy/valid/data %h, expected %h",
                     tag, k, obs[k], {1'b1, 1'b0, 32'h0});
         end
      end
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      reset_dut("reset");
      for (int i = 0; i < 20; i++) begin
         idle();
         for (int k = 0; k < 2; k++) begin
            checks++;
            if (obs[k] !== exp_o[k]) begin
               errors++;
               $display("FAIL reset_clear dut%0d cyc %0d: got %h, expected %h", k, cyc, obs[k], exp_o[k]);
            end
         end
      end
   endtask

   task automatic test_clear_readback();
      for (int i = 0; i < 18; i++) begin
         if (i < 16) step(1'b0, '0, '0, 4'h0, 1'b1, AW'(i));
         else idle();
         for (int k = 0; k < 2; k++) begin
            checks++;
            if (obs[k] !== exp_o[k]) begin
               errors++;
               $display("FAIL clear_readback dut%0d cyc %0d: got %h, expected %h", k, cyc, obs[k], exp_o[k]);
            end
         end
      end
   endtask

   task automatic test_byte_enable();
      for (int i = 0; i < 5; i++) begin
         case (i)
            0: step(1'b1, 4'd3, 32'hDEADBEEF, 4'b1111, 1'b0, '0);
            1: step(1'b1, 4'd3, 32'h11223344, 4'b0101, 1'b0, '0);
            2: step(1'b0, '0, '0, 4'h0, 1'b1, 4'd3);
            default: idle();
         endcase
         for (int k = 0; k < 2; k++) begin
            checks++;
            if (obs[k] !== exp_o[k]) begin
               errors++;
               $display("FAIL byte_enable dut%0d cyc %0d: got %h, expected %h", k, cyc, obs[k], exp_o[k]);
            end
         end
      end
      // Spot value independent of the model.
      checks++;
      if (if_b.rd_data !== 32'hDE22BE44) begin
         errors++;
         $display("FAIL byte_enable_value: got %h, expected %h", if_b.rd_data, 32'hDE22BE44);
      end
   endtask

   task automatic test_collision();
      for (int i = 0; i < 6; i++) begin
         case (i)
            0: step(1'b1, 4'd5, 32'hAAAAAAAA, 4'b1111, 1'b0, '0);
            1: step(1'b1, 4'd5, 32'h55555555, 4'b0011, 1'b1, 4'd5);
            3: step(1'b0, '0, '0, 4'h0, 1'b1, 4'd5);
            default: idle();
         endcase
         for (int k = 0; k < 2; k++) begin
            checks++;
            if (obs[k] !== exp_o[k]) begin
               errors++;
               $display("FAIL collision dut%0d cyc %0d: got %h, expected %h", k, cyc, obs[k], exp_o[k]);
            end
         end
         if (i == 1) begin
            checks++;
            if (if_a.rd_data !== 32'hAAAA5555) begin
               errors++;
               $display("FAIL collision_write_first: got %h, expected %h", if_a.rd_data, 32'hAAAA5555);
            end
         end
         if (i == 2) begin
            checks++;
            if (if_b.rd_data !== 32'hAAAAAAAA) begin
               errors++;
               $display("FAIL collision_read_first: got %h, expected %h", if_b.rd_data, 32'hAAAAAAAA);
            end
         end
      end
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 34; i++) begin
         if (i < 16) step(1'b1, AW'(i), $urandom, 4'($urandom_range(0, 15)), 1'b0, '0);
         else if (i < 32) step(1'b0, '0, '0, 4'h0, 1'b1, AW'(i - 16));
         else idle();
         for (int k = 0; k < 2; k++) begin
            checks++;
            if (obs[k] !== exp_o[k]) begin
               errors++;
               $display("FAIL back_to_back dut%0d cyc %0d: got %h, expected %h", k, cyc, obs[k], exp_o[k]);
            end
         end
      end
   endtask

   task automatic test_random();
      logic [AW-1:0] wa;
      for (int i = 0; i < 300; i++) begin
         wa = AW'($urandom_range(0, 15));
         step(1'($urandom_range(0, 1)), wa, $urandom, 4'($urandom_range(0, 15)),
              1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0) ? wa : AW'($urandom_range(0, 15)));
         for (int k = 0; k < 2; k++) begin
            checks++;
            if (obs[k] !== exp_o[k]) begin
               errors++;
               $display("FAIL random dut%0d cyc %0d: got %h, expected %h", k, cyc, obs[k], exp_o[k]);
            end
         end
      end
   endtask

   task automatic test_reset_mid_init();
      reset_dut("mid_init_first");
      repeat (7) idle();
      reset_dut("mid_init_second");
      for (int i = 0; i < 20; i++) begin
         step(1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)), $urandom, 4'hF,
              1'b1, AW'($urandom_range(0, 15)));
         for (int k = 0; k < 2; k++) begin
            checks++;
            if (obs[k] !== exp_o[k]) begin
               errors++;
               $display("FAIL reset_mid_init dut%0d cyc %0d: got %h, expected %h", k, cyc, obs[k], exp_o[k]);
            end
         end
      end
   endtask

   task automatic test_reset_mid_read();
      step(1'b1, 4'd2, 32'hCAFEF00D, 4'hF, 1'b0, '0);
      step(1'b0, '0, '0, 4'h0, 1'b1, 4'd2);
      reset_dut("reset_mid_read");
      for (int i = 0; i < 18; i++) begin
         idle();
         for (int k = 0; k < 2; k++) begin
            checks++;
            if (obs[k] !== exp_o[k]) begin
               errors++;
               $display("FAIL reset_mid_read dut%0d cyc %0d: got %h, expected %h", k, cyc, obs[k], exp_o[k]);
            end
         end
      end
   endtask

   initial begin
      repeat (2) @(negedge clk);
      test_reset();
      test_clear_readback();
      test_byte_enable();
      test_collision();
      test_back_to_back();
      test_random();
      test_reset_mid_init();
      test_reset_mid_read();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
